pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Central stall/flush sequencer for the five-stage MIPS32 pipeline. It drives the `enable` and `reset` inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves per-stage stall requests, exception flushes and branch-likely nullification, and sequences the multi-cycle divider so HI/LO reads stall until the result is ready.

## Interface
Parameters:
- `DIV_CYCLES`, 32: cycles from divide launch to result valid (2..63).

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `if_stall`  in  1  instruction memory not ready.
- `id_load_use`  in  1  load-use hazard detected in ID.
- `ex_hilo_read`  in  1  EX instruction reads HI/LO (mfhi/mflo).
- `ex_div_start`  in  1  EX issues div/divu; valid only when EX is not stalled.
- `dm_stall`  in  1  data memory not ready (MEM stage).
- `mem_exc_req`  in  1  exception detected in MEM.
- `id_bl_nullify`  in  1  branch-likely not taken; delay slot is in IF.
- `pc_enable`, `if_id_enable`, `id_ex_enable`, `ex_mem_enable`, `mem_wb_enable`  out  1 each  register load enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1 each  drive the register `reset` (bubble insert).
- `pc_sel_vector`  out  1  PC loads the exception vector this cycle.
- `div_busy`  out  1  divider in progress.
- `div_done`  out  1  one-cycle pulse when the result is written to HI/LO.

## Operation
- Stall by stage. The stalling stage is S, one of IF, ID, EX or MEM. Every register feeding S or upstream of it holds (enable=0). The register immediately downstream of S flushes. All other registers load.
  - MEM stall: `dm_stall`.
  - EX stall: `ex_hilo_read & div_busy`.
  - ID stall: `id_load_use`.
  - IF stall: `if_stall`.
- Deepest stage wins. Example: dm_stall together with id_load_use gives MEM behaviour only.
- Branch-likely: `id_bl_nullify` flushes IF/ID when no ID-or-deeper stall is active. If an IF stall is also active, the IF/ID flush from the stall is identical, so there is no conflict.
- Exception FSM has three states: IDLE, PENDING, FLUSH.
  - IDLE with mem_exc_req and dm_stall=0 → asserts the flush combinationally this cycle, stays IDLE.
  - IDLE with mem_exc_req and dm_stall=1 → PENDING.
  - PENDING → stays while dm_stall=1. On dm_stall=0, asserts the flush that cycle and returns to IDLE, whether or not mem_exc_req is still high.
  - Flush action: if_id, id_ex and ex_mem flush; pc_sel_vector=1; pc_enable=1; mem_wb loads normally. This overrides all lower-priority stalls and nullify.
- Divider sequencer: a counter with width `$clog2(DIV_CYCLES+1)`.
  - `ex_div_start` while idle loads DIV_CYCLES-1 and sets div_busy.
  - Decrements each cycle. At 0, div_busy clears and div_done pulses for that cycle.
  - `ex_div_start` while busy restarts the count from DIV_CYCLES-1 (MIPS overwrite semantics); no div_done is emitted for the abandoned operation.
  - Exceptions do not cancel an in-flight divide.
- The PC holds whenever IF/ID holds.

## Timing
- Reset values (during and after a reset cycle):
  - all enables = 0, all flushes = 1, pc_sel_vector = 0.
  - div_busy = 0, div_done = 0, counter = 0, FSM = IDLE.
- First cycle after reset is deasserted: all enables = 1, all flushes = 0.
- Stall and flush outputs are combinational from inputs and state, with zero latency. Only the FSM state and the divider counter are registered.
- Divide started at cycle n: div_busy is high in cycles n+1 .. n+DIV_CYCLES, and div_done pulses in cycle n+DIV_CYCLES.
- A HI/LO read in EX during cycle n+DIV_CYCLES is still stalled. It proceeds at cycle n+DIV_CYCLES+1.
- Reset mid-divide or while PENDING returns to reset values on the next edge.

## Structure
- Package `pipeline_pkg`:
  - stage encoding constants STAGE_NONE, STAGE_IF, STAGE_ID, STAGE_EX, STAGE_MEM;
  - exception FSM state constants;
  - the default DIV_CYCLES.
- Sub-module `div_sequencer`: the counter, div_busy and div_done. Its ports are clock, reset, start, busy, done.
- The stage-priority encoder and the exception FSM live in the top module.

## Test plan
- Reset held 2 cycles, then released → all flushes = 1 and enables = 0 during reset; all enables = 1 and flushes = 0 in the first cycle after release.
- id_load_use=1 for one cycle → pc_enable=0, if_id_enable=0, id_ex_flush=1; ex_mem and mem_wb enables = 1.
- dm_stall=1 and id_load_use=1 together → PC through EX/MEM hold, mem_wb_flush=1, id_ex_flush=0.
- ex_div_start at cycle 10 with DIV_CYCLES=32, ex_hilo_read held high from cycle 12 → EX stall and ex_mem_flush=1 through cycle 42; div_done=1 only at cycle 42; no stall at cycle 43.
- mem_exc_req=1 at cycle 5 with dm_stall=1 through cycle 8, exc_req dropped at cycle 6 → no flush in cycles 5–8; cycle 9 has if_id, id_ex and ex_mem flush plus pc_sel_vector=1.
- ex_div_start at cycle 0, again at cycle 5 → div_busy stays high, single div_done at cycle 5+DIV_CYCLES, none at cycle DIV_CYCLES.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the MIPS32 pipeline stall/flush controller.
package pipeline_pkg;

  localparam int DIV_CYCLES_DEFAULT = 32;

  // Stall sources, listed from shallowest to deepest pipeline stage.
  typedef enum logic [2:0] {
    STAGE_NONE,
    STAGE_IF,
    STAGE_ID,
    STAGE_EX,
    STAGE_MEM
  } stage_t;

  typedef enum logic [1:0] {
    EXC_IDLE,
    EXC_PENDING,
    EXC_FLUSH
  } exc_state_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Stall-request inputs and register-control outputs of the pipeline controller.
interface pipeline_controller_if;

  logic if_stall;
  logic id_load_use;
  logic ex_hilo_read;
  logic ex_div_start;
  logic dm_stall;
  logic mem_exc_req;
  logic id_bl_nullify;

  logic pc_enable;
  logic if_id_enable;
  logic id_ex_enable;
  logic ex_mem_enable;
  logic mem_wb_enable;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic pc_sel_vector;
  logic div_busy;
  logic div_done;

  modport master (
    input  if_stall, id_load_use, ex_hilo_read, ex_div_start,
           dm_stall, mem_exc_req, id_bl_nullify,
    output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_sel_vector, div_busy, div_done
  );

  modport slave (
    output if_stall, id_load_use, ex_hilo_read, ex_div_start,
           dm_stall, mem_exc_req, id_bl_nullify,
    input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_sel_vector, div_busy, div_done
  );

endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle divider sequencer: busy for DIV_CYCLES cycles after start,
// done pulses in the last busy cycle. A restart abandons the running divide.
module div_sequencer
  import pipeline_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      count <= CW'(DIV_CYCLES - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (count == '0) busy  <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign done = busy && (count == '0);

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the five-stage pipeline: deepest-stage stall
// priority, exception flush FSM, branch-likely nullify and divider sequencing.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_controller_if.master bus
);

  exc_state_t exc_state, exc_next, exc_mode;
  stage_t     stall_stage;
  logic       div_busy, div_done;

  div_sequencer #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clock (clock),
    .reset (reset),
    .start (bus.ex_div_start),
    .busy  (div_busy),
    .done  (div_done)
  );

  assign bus.div_busy = div_busy;
  assign bus.div_done = div_done;

  always_ff @(posedge clock) begin
    if (reset) exc_state <= EXC_IDLE;
    else       exc_state <= exc_next;
  end

  // The flush cycle is combinational, so EXC_FLUSH appears only as the
  // current mode and is never registered.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    exc_next = exc_state;
    exc_mode = exc_state;
    unique case (exc_state)
      EXC_IDLE: begin
        if (bus.mem_exc_req) begin
          if (bus.dm_stall) exc_next = EXC_PENDING;
          else              exc_mode = EXC_FLUSH;
        end
      end
      EXC_PENDING: begin
        if (!bus.dm_stall) begin
          exc_mode = EXC_FLUSH;
          exc_next = EXC_IDLE;
        end
      end
      default: exc_next = EXC_IDLE;
    endcase
  end

  always_comb begin
    stall_stage = STAGE_NONE;
    if (bus.dm_stall)                      stall_stage = STAGE_MEM;
    else if (bus.ex_hilo_read && div_busy) stall_stage = STAGE_EX;
    else if (bus.id_load_use)              stall_stage = STAGE_ID;
    else if (bus.if_stall)                 stall_stage = STAGE_IF;
  end

  always_comb begin
    bus.pc_enable     = 1'b1;
    bus.if_id_enable  = 1'b1;
    bus.id_ex_enable  = 1'b1;
    bus.ex_mem_enable = 1'b1;
    bus.mem_wb_enable = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.ex_mem_flush  = 1'b0;
    bus.mem_wb_flush  = 1'b0;
    bus.pc_sel_vector = 1'b0;

    if (reset) begin
      bus.pc_enable     = 1'b0;
      bus.if_id_enable  = 1'b0;
      bus.id_ex_enable  = 1'b0;
      bus.ex_mem_enable = 1'b0;
      bus.mem_wb_enable = 1'b0;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_flush   = 1'b1;
      bus.ex_mem_flush  = 1'b1;
      bus.mem_wb_flush  = 1'b1;
    end else if (exc_mode == EXC_FLUSH) begin
      bus.if_id_flush   = 1'b1;
      bus.id_ex_flush   = 1'b1;
      bus.ex_mem_flush  = 1'b1;
      bus.pc_sel_vector = 1'b1;
    end else begin
      // Registers upstream of the stalling stage hold; the one just below it flushes.
      unique case (stall_stage)
        STAGE_IF: begin
          bus.pc_enable   = 1'b0;
          bus.if_id_flush = 1'b1;
        end
        STAGE_ID: begin
          bus.pc_enable    = 1'b0;
          bus.if_id_enable = 1'b0;
          bus.id_ex_flush  = 1'b1;
        end
        STAGE_EX: begin
          bus.pc_enable    = 1'b0;
          bus.if_id_enable = 1'b0;
          bus.id_ex_enable = 1'b0;
          bus.ex_mem_flush = 1'b1;
        end
        STAGE_MEM: begin
          bus.pc_enable     = 1'b0;
          bus.if_id_enable  = 1'b0;
          bus.id_ex_enable  = 1'b0;
          bus.ex_mem_enable = 1'b0;
          bus.mem_wb_flush  = 1'b1;
        end
        default: ;
      endcase
      if (bus.id_bl_nullify && (stall_stage == STAGE_NONE || stall_stage == STAGE_IF))
        bus.if_id_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a cycle-count based reference model of the controller.
module tb_pipeline_controller;
  import pipeline_pkg::*;

  localparam int D = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pipeline_controller_if bus ();

  pipeline_controller #(.DIV_CYCLES(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  bit pend      = 1'b0;   // exception waiting for memory to become ready
  int div_end   = -1;     // cycle in which the latest divide completes
  int done_seen = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit model_busy();
    return (div_end >= 0) && (cyc <= div_end);
  endfunction

  task automatic step(input bit rst, input bit ifs, input bit lu, input bit hilo,
                      input bit start, input bit dm, input bit exc, input bit nul);
    logic [4:0] en_e, fl_e;
    logic       sel_e, busy_e, done_e;
    bit         fire;
    int         s;
    reset             = rst;
    bus.if_stall      = ifs;
    bus.id_load_use   = lu;
    bus.ex_hilo_read  = hilo;
    bus.ex_div_start  = start;
    bus.dm_stall      = dm;
    bus.mem_exc_req   = exc;
    bus.id_bl_nullify = nul;
    @(negedge clock);

    busy_e = model_busy();
    done_e = (cyc == div_end);
    s = dm ? 4 : (hilo && busy_e) ? 3 : lu ? 2 : ifs ? 1 : 0;
    fire = !rst && !dm && (pend || exc);
    sel_e = 1'b0;
    if (rst) begin
      en_e = 5'b00000;
      fl_e = 5'b11110;
    end else if (fire) begin
      en_e  = 5'b11111;
      fl_e  = 5'b01110;
      sel_e = 1'b1;
    end else begin
      // bit i is register i: 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB
      for (int i = 0; i < 5; i++) begin
        en_e[i] = (i >= s);
        fl_e[i] = (s != 0) && (i == s);
      end
      if (nul && s <= 1) fl_e[1] = 1'b1;
    end

    check("enables", {3'b0, bus.mem_wb_enable, bus.ex_mem_enable, bus.id_ex_enable,
                      bus.if_id_enable, bus.pc_enable}, {3'b0, en_e});
    check("flushes", {3'b0, bus.mem_wb_flush, bus.ex_mem_flush, bus.id_ex_flush,
                      bus.if_id_flush, 1'b0}, {3'b0, fl_e});
    check("pc_sel_vector", {7'b0, bus.pc_sel_vector}, {7'b0, sel_e});
    check("div_busy", {7'b0, bus.div_busy}, {7'b0, busy_e});
    check("div_done", {7'b0, bus.div_done}, {7'b0, done_e});
    if (bus.div_done === 1'b1) done_seen++;

    @(posedge clock);
    if (rst) begin
      pend    = 1'b0;
      div_end = -1;
    end else begin
      if (!pend && exc && dm) pend = 1'b1;
      else if (pend && !dm)   pend = 1'b0;
      if (start) div_end = cyc + D;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit ifs, lu, hilo, start, dm, exc, nul, rst;
    bus.if_stall = 0; bus.id_load_use = 0; bus.ex_hilo_read = 0; bus.ex_div_start = 0;
    bus.dm_stall = 0; bus.mem_exc_req = 0; bus.id_bl_nullify = 0;
    @(posedge clock);
    #1;

    // reset held, then released
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // load-use alone, then together with a data-memory stall
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 1);
    idle(1);

    // nullify alone, with an IF stall, and masked by an ID stall
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1);

    // divide, HI/LO read held until past completion
    done_seen = 0;
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < D + 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    check("div_done_count", 8'(done_seen), 8'd1);

    // exception while memory stalls, request dropped before memory is ready
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // immediate exception overriding an EX stall and nullify
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1, 1);
    idle(D + 1);

    // restart mid-divide: only the second divide reports done
    done_seen = 0;
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(D + 4);
    check("div_restart_done_count", 8'(done_seen), 8'd1);

    // reset while pending and mid-divide
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      ifs  = ($urandom_range(0, 3) == 0);
      lu   = ($urandom_range(0, 4) == 0);
      hilo = ($urandom_range(0, 2) == 0);
      dm   = ($urandom_range(0, 3) == 0);
      exc  = ($urandom_range(0, 9) == 0);
      nul  = ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 19) == 0) && !dm && !(hilo && model_busy())
              && !(pend || exc);
      step(rst, ifs, lu, hilo, start, dm, exc, nul);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
